sistema_embarcado_saida: RTL and testbench
==========================================

# sistema_embarcado_saida

Avalon-MM output PIO with a valid/ready handshake toward the accelerator fabric. It is the write-side counterpart of the system's input PIOs: the Nios II writes a 32-bit control word, and the block presents it on `out_port` with `out_valid` until the consumer asserts `out_ready`. It sits on the Nios data master's Avalon bus beside the input PIOs and drives command/configuration words into the RANSAC datapath. Status and completion flags are readable by software, and an optional completion IRQ is provided.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of the data register and of `out_port`; must be ≤ 32.
- `RESET_VALUE`, 0: reset value of the data register.

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select; writes are ignored when low.
- `write`  in  1  write strobe; qualified by `chipselect`.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data; reset 0.
- `out_port`  out  DATA_WIDTH  data register contents; reset `RESET_VALUE`.
- `out_valid`  out  1  word pending for the consumer; reset 0.
- `out_ready`  in  1  consumer accepts the word when high together with `out_valid`.
- `irq`  out  1  level interrupt; reset 0.

## Operation
Register map:
- 0 DATA: read/write. A write loads the register.
- 1 STATUS: bit0 PENDING (RO, equals `out_valid`), bit1 OVERRUN (sticky, W1C), bit2 IRQ_EN (RW), bit3 DONE (sticky, W1C). All other bits read 0.
- 2 OUTSET: write ORs `writedata` into DATA. Reads return 0.
- 3 OUTCLEAR: write ANDs `~writedata` into DATA. Reads return 0.

A "load" is an accepted write to address 0, 2 or 3. Loads are accepted only if the FSM is IDLE, or if it is PENDING and the handshake completes in the same cycle.

FSM states: IDLE and PENDING.
- IDLE: a load updates DATA and moves to PENDING.
- PENDING with `out_ready` = 1: the handshake completes and DONE is set. If a load occurs in the same cycle, DATA is updated and the FSM stays PENDING. Otherwise it moves to IDLE.
- PENDING with `out_ready` = 0: a load is dropped, DATA is unchanged, and OVERRUN is set.
- `out_valid` is high exactly while the FSM is PENDING.

Other rules:
- `irq` = IRQ_EN & DONE, registered.
- W1C writes to STATUS take priority below same-cycle sets: if a completion coincides with a W1C of DONE, DONE stays 1.
- Width rule: only `writedata[DATA_WIDTH-1:0]` is used. On reads, DATA is zero-extended to 32 bits.
- Reset mid-transaction: `out_valid` drops asynchronously, DATA returns to `RESET_VALUE`, and all flags clear. The consumer must discard any partial transfer.

## Timing
- Read latency 1: `readdata` is loaded every `clk` with the mux output for the current `address`, regardless of `chipselect`. There is no wait state.
- Write to `out_port`/`out_valid`: both update on the edge that samples the write. `out_valid` is high from the next cycle.
- Handshake: the word transfers on the edge where `out_valid` & `out_ready` are both 1. `out_valid` falls after that edge unless a load occurred in the same cycle.
- `out_port` is stable while `out_valid` = 1 with no completion.
- DONE, OVERRUN and `irq` update on the edge after the triggering event. `irq` lags DONE by one more cycle.
- Back-to-back loads at one per cycle are sustainable only while `out_ready` is held at 1.

## Structure
- Shared package `sistema_embarcado_pkg` holds:
  - register address constants `ADDR_DATA`, `ADDR_STATUS`, `ADDR_OUTSET`, `ADDR_OUTCLEAR`;
  - STATUS bit index constants;
  - the FSM state enum.
- One natural sub-module, `saida_status_regs`, holds the sticky/W1C flag logic and the IRQ register. The FSM and DATA register live in the top module.

## Test plan
- Reset with `RESET_VALUE` = 0x5A: `out_port` = 0x5A, `out_valid` = 0, `irq` = 0, `readdata` = 0. Read of address 1 returns 0.
- Write 0x1234 to DATA with `out_ready` = 0: `out_valid` = 1 from the next cycle and holds. Raising `out_ready` for 1 cycle drops `out_valid`. STATUS then reads 0x8.
- While PENDING with `out_ready` = 0, write 0xFFFF to DATA: `out_port` stays 0x1234 and STATUS reads 0x3. W1C of 0x2 then gives STATUS 0x1.
- DATA = 0x00F0: OUTSET 0x000F then OUTCLEAR 0x00F0, each acknowledged, give `out_port` 0x000F. Reads of addresses 2 and 3 return 0.
- `out_ready` held at 1 with loads 0x1, 0x2, 0x3 on consecutive cycles: the consumer sees three transfers, OVERRUN stays 0, and `out_valid` drops one cycle after the last.
- IRQ_EN = 1, one transfer: `irq` = 1 two cycles after the handshake. W1C DONE clears `irq`. `reset_n` asserted mid-PENDING clears `out_valid` immediately.

Source files
------------

// File: rtl/sistema_embarcado_pkg.sv
// Shared constants and types for the output PIO: register map, STATUS bit layout, FSM states.
package sistema_embarcado_pkg;

    // Register map
    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_STATUS   = 2'd1;
    localparam logic [1:0] ADDR_OUTSET   = 2'd2;
    localparam logic [1:0] ADDR_OUTCLEAR = 2'd3;

    // STATUS register bit positions
    localparam int unsigned STATUS_PENDING_BIT = 0;
    localparam int unsigned STATUS_OVERRUN_BIT = 1;
    localparam int unsigned STATUS_IRQ_EN_BIT  = 2;
    localparam int unsigned STATUS_DONE_BIT    = 3;

    // Output handshake FSM
    typedef enum logic {
        StIdle,
        StPending
    } saida_state_e;

endpackage

// File: rtl/saida_status_regs.sv
// Sticky/W1C status flags (OVERRUN, DONE), the IRQ enable bit and the registered interrupt.
module saida_status_regs
    import sistema_embarcado_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic status_wr_i,
    input  logic irq_en_wdata_i,
    input  logic overrun_clr_i,
    input  logic done_clr_i,
    input  logic overrun_set_i,
    input  logic done_set_i,
    output logic irq_en_o,
    output logic overrun_o,
    output logic done_o,
    output logic irq_o
);

    logic irq_en_q, irq_en_d;
    logic overrun_q, overrun_d;
    logic done_q, done_d;
    logic irq_q, irq_d;

    // Next-state: software clears first, hardware sets override them in the same cycle
    always_comb begin
        irq_en_d  = irq_en_q;
        overrun_d = overrun_q;
        done_d    = done_q;
        if (status_wr_i) begin
            irq_en_d = irq_en_wdata_i;
            if (overrun_clr_i) begin
                overrun_d = 1'b0;
            end
            if (done_clr_i) begin
                done_d = 1'b0;
            end
        end
        if (overrun_set_i) begin
            overrun_d = 1'b1;
        end
        if (done_set_i) begin
            done_d = 1'b1;
        end
        // irq follows the registered flags, so it lags DONE by one cycle
        irq_d = irq_en_q & done_q;
    end

    // Flag and interrupt registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q  <= 1'b0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            irq_en_q  <= irq_en_d;
            overrun_q <= overrun_d;
            done_q    <= done_d;
            irq_q     <= irq_d;
        end
    end

    assign irq_en_o  = irq_en_q;
    assign overrun_o = overrun_q;
    assign done_o    = done_q;
    assign irq_o     = irq_q;

endmodule

// File: rtl/sistema_embarcado_saida.sv
// Avalon-MM output PIO: software loads a word, block presents it with valid/ready to the fabric.
module sistema_embarcado_saida
    import sistema_embarcado_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  irq
);

    saida_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] wdata;
    logic [31:0]           readdata_q, readdata_d;

    logic wr_en;
    logic status_wr;
    logic load_req;
    logic handshake;
    logic load_ok;
    logic overrun_set;
    logic irq_en;
    logic overrun;
    logic done;

    assign wdata = writedata[DATA_WIDTH-1:0];

    // Decode bus writes and decide whether a load is accepted this cycle
    always_comb begin
        wr_en       = chipselect & write;
        status_wr   = wr_en & (address == ADDR_STATUS);
        load_req    = wr_en & (address != ADDR_STATUS);
        handshake   = (state_q == StPending) & out_ready;
        // A new word may only replace one that is being consumed on this very edge
        load_ok     = load_req & ((state_q == StIdle) | handshake);
        overrun_set = load_req & (state_q == StPending) & ~out_ready;
    end

    // Next DATA value and next FSM state
    always_comb begin
        data_d  = data_q;
        state_d = state_q;
        if (load_ok) begin
            case (address)
                ADDR_DATA:     data_d = wdata;
                ADDR_OUTSET:   data_d = data_q | wdata;
                ADDR_OUTCLEAR: data_d = data_q & ~wdata;
                default:       data_d = data_q;
            endcase
            state_d = StPending;
        end else if (handshake) begin
            state_d = StIdle;
        end
    end

    // Read mux, sampled every cycle regardless of chipselect
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA: begin
                readdata_d[DATA_WIDTH-1:0] = data_q;
            end
            ADDR_STATUS: begin
                readdata_d[STATUS_PENDING_BIT] = (state_q == StPending);
                readdata_d[STATUS_OVERRUN_BIT] = overrun;
                readdata_d[STATUS_IRQ_EN_BIT]  = irq_en;
                readdata_d[STATUS_DONE_BIT]    = done;
            end
            default: begin
                readdata_d = '0;
            end
        endcase
    end

    // FSM state, DATA register and read data register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            data_q     <= RESET_VALUE[DATA_WIDTH-1:0];
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            readdata_q <= readdata_d;
        end
    end

    saida_status_regs u_status_regs (
        .clk            (clk),
        .reset_n        (reset_n),
        .status_wr_i    (status_wr),
        .irq_en_wdata_i (writedata[STATUS_IRQ_EN_BIT]),
        .overrun_clr_i  (writedata[STATUS_OVERRUN_BIT]),
        .done_clr_i     (writedata[STATUS_DONE_BIT]),
        .overrun_set_i  (overrun_set),
        .done_set_i     (handshake),
        .irq_en_o       (irq_en),
        .overrun_o      (overrun),
        .done_o         (done),
        .irq_o          (irq)
    );

    assign out_port  = data_q;
    assign out_valid = (state_q == StPending);
    assign readdata  = readdata_q;

endmodule

// File: tb/tb_sistema_embarcado_saida.sv
// Scoreboard bench for the output PIO: a driver updates a transaction-level model and queues
// expectations; a monitor on the falling edge compares transfers, outputs and read data.
module tb_sistema_embarcado_saida;

    localparam int unsigned DW      = 32;
    localparam logic [31:0] RST_VAL = 32'h0000_005A;
    localparam logic [31:0] MASK    = 32'hFFFF_FFFF >> (32 - DW);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    address;
    logic          chipselect;
    logic          write;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [DW-1:0] out_port;
    logic          out_valid;
    logic          out_ready;
    logic          irq;

    sistema_embarcado_saida #(
        .DATA_WIDTH  (DW),
        .RESET_VALUE (RST_VAL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          due;
        logic        v;
        logic        irq;
        logic [31:0] port;
    } st_t;

    typedef struct {
        int          due;
        logic [31:0] val;
    } rd_t;

    st_t         sq[$];
    rd_t         rq[$];
    logic [31:0] xq[$];

    // Software-visible model of the block
    logic [31:0] m_word;
    bit          m_pend, m_ovr, m_done, m_ien, m_irq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_word = RST_VAL & MASK;
        m_pend = 0;
        m_ovr  = 0;
        m_done = 0;
        m_ien  = 0;
        m_irq  = 0;
    endtask

    // Drive one bus/consumer cycle and record what must follow from it
    task automatic step(input int cs, input int wr, input int a, input logic [31:0] wd,
                        input int rdy);
        logic [31:0] rv;
        bit          is_load, is_stat, hs, nirq;
        @(posedge clk);
        #2;
        chipselect = (cs != 0);
        write      = (wr != 0);
        address    = 2'(a);
        writedata  = wd;
        out_ready  = (rdy != 0);

        case (a)
            0:       rv = m_word;
            1:       rv = {28'd0, m_done, m_ien, m_ovr, m_pend};
            default: rv = 32'd0;
        endcase
        rq.push_back('{cyc + 1, rv});

        is_stat = (cs != 0) && (wr != 0) && (a == 1);
        is_load = (cs != 0) && (wr != 0) && (a != 1);
        hs      = m_pend && (rdy != 0);
        nirq    = m_ien && m_done;

        if (is_stat) begin
            m_ien = wd[2];
            if (wd[1]) m_ovr = 0;
            if (wd[3]) m_done = 0;
        end
        if (hs) m_done = 1;
        if (is_load) begin
            if (!m_pend || rdy != 0) begin
                case (a)
                    0:       m_word = wd & MASK;
                    2:       m_word = m_word | (wd & MASK);
                    default: m_word = m_word & ~wd & MASK;
                endcase
                xq.push_back(m_word);
                m_pend = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (hs) begin
            m_pend = 0;
        end
        m_irq = nirq;
        sq.push_back('{cyc + 1, m_pend, m_irq, m_word});
    endtask

    // Monitor: transfers, then due output-state and read-data expectations
    initial begin
        forever begin
            st_t         e;
            rd_t         r;
            logic [31:0] w;
            @(negedge clk);
            if (reset_n) begin
                if (out_valid && out_ready) begin
                    if (xq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL xfer at cycle %0d: got word %h, want no transfer",
                                 cyc, out_port);
                    end else begin
                        w = xq.pop_front();
                        chk("xfer", 32'(out_port), w);
                    end
                end
                while (sq.size() > 0 && sq[0].due <= cyc) begin
                    e = sq.pop_front();
                    chk("out_valid", 32'(out_valid), 32'(e.v));
                    chk("irq", 32'(irq), 32'(e.irq));
                    chk("out_port", 32'(out_port), e.port);
                end
                while (rq.size() > 0 && rq[0].due <= cyc) begin
                    r = rq.pop_front();
                    chk("readdata", readdata, r.val);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        chipselect = 1'b0;
        write      = 1'b0;
        address    = 2'd1;
        writedata  = 32'd0;
        out_ready  = 1'b0;

        // Reset state
        #12;
        chk("rst_out_port", 32'(out_port), RST_VAL);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        #10 reset_n = 1'b1;
        model_reset();

        // STATUS after reset, then a single word with a stalled consumer
        step(1, 0, 1, 32'd0, 0);
        step(1, 1, 0, 32'h1234, 0);
        repeat (3) step(0, 0, 1, 32'd0, 0);
        step(0, 0, 1, 32'd0, 1);
        repeat (2) step(0, 0, 1, 32'd0, 0);

        // Overrun while pending, then W1C of OVERRUN
        step(1, 1, 1, 32'h8, 0);
        step(1, 1, 0, 32'h1234, 0);
        step(1, 1, 0, 32'hFFFF, 0);
        step(0, 0, 1, 32'd0, 0);
        step(1, 1, 1, 32'h2, 0);
        step(0, 0, 1, 32'd0, 0);
        step(0, 0, 0, 32'd0, 1);

        // OUTSET / OUTCLEAR
        step(1, 1, 0, 32'h00F0, 1);
        step(0, 0, 2, 32'd0, 1);
        step(1, 1, 2, 32'h000F, 1);
        step(0, 0, 3, 32'd0, 1);
        step(1, 1, 3, 32'h00F0, 1);
        step(0, 0, 0, 32'd0, 1);
        step(0, 0, 0, 32'd0, 0);

        // Back-to-back loads with the consumer always ready
        step(1, 1, 0, 32'h1, 1);
        step(1, 1, 0, 32'h2, 1);
        step(1, 1, 0, 32'h3, 1);
        step(0, 0, 1, 32'd0, 1);
        step(0, 0, 1, 32'd0, 0);

        // Interrupt after a completion, cleared by W1C of DONE
        step(1, 1, 1, 32'hE, 0);
        step(1, 1, 0, 32'hAB, 0);
        step(0, 0, 1, 32'd0, 1);
        repeat (3) step(0, 0, 1, 32'd0, 0);
        step(1, 1, 1, 32'hC, 0);
        repeat (2) step(0, 0, 1, 32'd0, 0);

        // Completion coinciding with W1C of DONE keeps DONE set
        step(1, 1, 0, 32'h55, 0);
        step(1, 1, 1, 32'hC, 1);
        repeat (3) step(0, 0, 1, 32'd0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step((($urandom % 4) != 0) ? 1 : 0, (($urandom % 3) != 0) ? 1 : 0,
                 int'($urandom % 4), $urandom, (($urandom % 5) < 3) ? 1 : 0);
        end

        // Reset in the middle of a pending transfer
        step(1, 1, 1, 32'hA, 1);
        step(0, 0, 0, 32'd0, 1);
        step(1, 1, 0, 32'h0BEE, 0);
        step(0, 0, 0, 32'd0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_valid", 32'(out_valid), 32'd0);
        chk("async_reset_port", 32'(out_port), RST_VAL);
        chk("async_reset_irq", 32'(irq), 32'd0);
        xq.delete();
        sq.delete();
        rq.delete();
        model_reset();
        #2 reset_n = 1'b1;

        step(0, 0, 1, 32'd0, 0);
        for (int i = 0; i < 60; i++) begin
            step((($urandom % 2) != 0) ? 1 : 0, 1, int'($urandom % 4), $urandom,
                 (($urandom % 2) != 0) ? 1 : 0);
        end

        // Drain
        repeat (4) step(0, 0, 1, 32'd0, 1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("xfer_drain", 32'(xq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
